fetch_unit: RTL and testbench

Instruction fetch stage for the 8-bit CPU. It sits directly upstream of the decode stage. It owns the program counter and reads 32-bit instruction words from a synchronous 64-word instruction memory. It presents one instruction per cycle to decode with a valid/ready handshake, and redirects on the decode stage's jump outputs (`jmp_sig`, `jmp_sig_c`, `jmp_add`). It also stops fetching on a halt opcode and counts retired instructions.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/pc_reg.sv | 23 ++
 rtl/fetch_unit.sv | 70 +++++++
 tb/tb_fetch_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: widths, halt opcode, decode opcodes and fetch state enum shared across the CPU
package cpu_pkg;
    localparam int ADDR_W = 6;
    localparam int INST_W = 32;
    localparam logic [7:0] HALT_OP = 8'hFF;
    localparam logic [7:0] OP_01 = 8'h01;
    localparam logic [7:0] OP_02 = 8'h02;
    localparam logic [7:0] OP_03 = 8'h03;
    localparam logic [7:0] OP_04 = 8'h04;
    localparam logic [7:0] OP_05 = 8'h05;
    localparam logic [7:0] OP_06 = 8'h06;
    localparam logic [7:0] OP_07 = 8'h07;
    localparam logic [7:0] OP_08 = 8'h08;
    localparam logic [7:0] OP_09 = 8'h09;
    localparam logic [7:0] OP_10 = 8'h10;
    localparam logic [7:0] OP_1F = 8'h1f;
    localparam logic [7:0] OP_20 = 8'h20;
    localparam logic [7:0] OP_21 = 8'h21;
    typedef enum logic [1:0] {LOAD, RUN, HALT} fetch_state_t;
endpackage

// File: rtl/pc_reg.sv
// pc_reg: program counter register with load, increment and hold
// Ports: clk, rst (async active-low), load_i/load_val_i (jump target), inc_i (advance), pc_o (current PC)
module pc_reg #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         inc_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] pc_o
);
    logic [W-1:0] pc_q, pc_d;

    // Load wins over increment; increment wraps modulo 2^W
    always_comb pc_d = load_i ? load_val_i : inc_i ? pc_q + W'(1) : pc_q;

    always_ff @(posedge clk or negedge rst)
        if (!rst) pc_q <= '0;
        else      pc_q <= pc_d;

    assign pc_o = pc_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with PC, synchronous imem read, valid/ready to decode, jump redirect and halt
// Ports: clk, rst (async active-low); imem_en/imem_addr/imem_data (1-cycle sync memory);
//        inst/inst_valid/inst_ready/inst_pc (decode handshake); jmp_sig/jmp_sig_c/cond/jmp_add (redirect);
//        halted, retired_cnt (status)
import cpu_pkg::*;

module fetch_unit #(
    parameter int         ADDR_W  = cpu_pkg::ADDR_W,
    parameter int         INST_W  = cpu_pkg::INST_W,
    parameter logic [7:0] HALT_OP = cpu_pkg::HALT_OP
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_data,
    output logic [INST_W-1:0] inst,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              jmp_sig,
    input  logic              jmp_sig_c,
    input  logic              cond,
    input  logic [ADDR_W-1:0] jmp_add,
    output logic              halted,
    output logic [7:0]        retired_cnt
);
    fetch_state_t      state_q;
    logic [ADDR_W-1:0] pc_q, req_pc_q;
    logic [7:0]        cnt_q;
    logic              load, run, hs, halt, take, adv;

    assign load = state_q == LOAD;
    assign run  = state_q == RUN;
    assign hs   = run & inst_ready;
    assign halt = hs & (inst[INST_W-1 -: 8] == HALT_OP);
    // Halt outranks a jump on the same instruction
    assign take = hs & ~halt & (jmp_sig | (jmp_sig_c & cond));
    // Sequential advance: boot/redirect load, or an accepted non-control instruction
    assign adv  = load | (hs & ~halt & ~take);

    pc_reg #(.W(ADDR_W)) u_pc (
        .clk        (clk),
        .rst        (rst),
        .load_i     (take),
        .inc_i      (adv),
        .load_val_i (jmp_add),
        .pc_o       (pc_q)
    );

    // A stall re-reads req_pc so the word on imem_data stays put; jmp_add never reaches the address
    assign imem_en     = rst & (load | (run & ~halt & ~take));
    assign imem_addr   = (run & ~hs) ? req_pc_q : pc_q;
    assign inst        = imem_data;
    assign inst_valid  = run;
    assign inst_pc     = req_pc_q;
    assign halted      = state_q == HALT;
    assign retired_cnt = cnt_q;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state_q  <= LOAD;
            req_pc_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (adv) req_pc_q <= pc_q;
            if (hs)  cnt_q    <= cnt_q + 8'd1;
            state_q <= load ? RUN : halt ? HALT : take ? LOAD : state_q;
        end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scenario tasks plus randomized run checked against a presented-instruction reference model
module tb_fetch_unit;
    logic        clk = 0, rst = 0;
    logic        imem_en, inst_valid, inst_ready, jmp_sig, jmp_sig_c, cond, halted;
    logic [5:0]  imem_addr, inst_pc, jmp_add;
    logic [31:0] imem_data = '0, inst;
    logic [7:0]  retired_cnt;
    logic [31:0] mem [64];
    int          errors = 0, checks = 0;

    // Model: which instruction decode sees, plus pending redirect and status
    bit          m_valid, m_bub, m_halt;
    logic [5:0]  m_pc, m_tgt;
    logic [7:0]  m_cnt;

    fetch_unit dut (
        .clk(clk), .rst(rst), .imem_en(imem_en), .imem_addr(imem_addr), .imem_data(imem_data),
        .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_pc(inst_pc),
        .jmp_sig(jmp_sig), .jmp_sig_c(jmp_sig_c), .cond(cond), .jmp_add(jmp_add),
        .halted(halted), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (imem_en) imem_data <= mem[imem_addr];

    task drive(input logic rdy, input logic js, input logic jc, input logic c, input logic [5:0] ja);
        inst_ready = rdy; jmp_sig = js; jmp_sig_c = jc; cond = c; jmp_add = ja;
    endtask

    task model_reset();
        m_valid = 0; m_bub = 1; m_tgt = 0; m_pc = 0; m_halt = 0; m_cnt = 0;
    endtask

    // Advance one clock; model reacts to the inputs held across the edge
    task tick();
        bit hs;
        hs = m_valid && inst_ready;
        if (m_bub) begin
            m_bub = 0; m_valid = 1; m_pc = m_tgt;
        end else if (hs) begin
            m_cnt = m_cnt + 1;
            if (mem[m_pc][31:24] == 8'hFF) begin
                m_valid = 0; m_halt = 1;
            end else if (jmp_sig || (jmp_sig_c && cond)) begin
                m_valid = 0; m_bub = 1; m_tgt = jmp_add;
            end else m_pc = m_pc + 1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task hold_reset();
        rst = 0;
        model_reset();
        @(negedge clk);
        rst = 1;
    endtask

    task test_reset();
        for (int i = 0; i < 64; i++) mem[i] = i;
        drive(1, 1, 0, 0, 6'h15);
        rst = 0;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", inst_valid); end
            checks++; if (imem_en !== 1'b0) begin errors++; $display("FAIL reset_imem_en got=%0b exp=0", imem_en); end
            checks++; if (retired_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", retired_cnt); end
            checks++; if (inst_pc !== 6'd0 || halted !== 1'b0) begin errors++; $display("FAIL reset_pc_halted got=%0d/%0b exp=0/0", inst_pc, halted); end
            @(negedge clk);
        end
        drive(1, 0, 0, 0, 0);
        rst = 1;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL boot_valid_pre got=%0b exp=0", inst_valid); end
        tick();
        for (int i = 0; i < 2; i++) begin
            checks++; if (inst_valid !== 1'b1 || inst_pc !== 6'(i)) begin errors++; $display("FAIL boot_pc got=%0b/%0d exp=1/%0d", inst_valid, inst_pc, i); end
            checks++; if (inst !== 32'(i)) begin errors++; $display("FAIL boot_inst got=%0h exp=%0h", inst, i); end
            tick();
        end
    endtask

    task test_stall();
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 0);
            #1;
            checks++; if (imem_addr !== 6'd2 || imem_en !== 1'b1) begin errors++; $display("FAIL stall_addr got=%0d/%0b exp=2/1", imem_addr, imem_en); end
            checks++; if (inst_pc !== 6'd2 || inst !== 32'd2 || inst_valid !== 1'b1) begin errors++; $display("FAIL stall_hold got=%0d/%0h exp=2/2", inst_pc, inst); end
            checks++; if (retired_cnt !== 8'd2) begin errors++; $display("FAIL stall_cnt got=%0d exp=2", retired_cnt); end
            tick();
        end
        drive(1, 0, 0, 0, 0);
        for (int e = 2; e < 4; e++) begin
            checks++; if (inst_pc !== 6'(e) || inst !== 32'(e)) begin errors++; $display("FAIL stall_resume got=%0d exp=%0d", inst_pc, e); end
            tick();
        end
    endtask

    task test_jump();
        checks++; if (inst_pc !== 6'd4) begin errors++; $display("FAIL jump_start got=%0d exp=4", inst_pc); end
        drive(1, 1, 0, 0, 6'h20);
        tick();
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL jump_bubble got=%0b exp=0", inst_valid); end
        checks++; if (retired_cnt !== 8'd5) begin errors++; $display("FAIL jump_cnt got=%0d exp=5", retired_cnt); end
        drive(1, 0, 0, 0, 0);
        tick();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 6'h20 || inst !== 32'h20) begin errors++; $display("FAIL jump_target got=%0d exp=32", inst_pc); end
        tick();
        checks++; if (inst_pc !== 6'h21 || retired_cnt !== 8'd6) begin errors++; $display("FAIL jump_next got=%0d/%0d exp=33/6", inst_pc, retired_cnt); end
    endtask

    task test_cond();
        drive(1, 0, 1, 0, 6'h05);
        tick();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 6'h22) begin errors++; $display("FAIL cond0_seq got=%0d exp=34", inst_pc); end
        drive(1, 0, 1, 1, 6'h10);
        tick();
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL cond1_bubble got=%0b exp=0", inst_valid); end
        drive(1, 0, 0, 0, 0);
        tick();
        checks++; if (inst_pc !== 6'h10 || inst !== 32'h10) begin errors++; $display("FAIL cond1_target got=%0d exp=16", inst_pc); end
        drive(0, 1, 0, 0, 6'h30);
        tick();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 6'h10 || retired_cnt !== m_cnt) begin errors++; $display("FAIL jmp_noready got=%0d/%0d exp=16/%0d", inst_pc, retired_cnt, m_cnt); end
        drive(1, 0, 0, 0, 0);
        tick();
        checks++; if (inst_pc !== 6'h11) begin errors++; $display("FAIL jmp_noready_next got=%0d exp=17", inst_pc); end
    endtask

    task test_wrap();
        drive(1, 1, 0, 0, 6'h3E);
        tick();
        drive(1, 0, 0, 0, 0);
        tick();
        for (int e = 0; e < 3; e++) begin
            checks++; if (inst_valid !== 1'b1 || inst_pc !== 6'(62 + e)) begin errors++; $display("FAIL wrap got=%0d exp=%0d", inst_pc, 6'(62 + e)); end
            tick();
        end
    endtask

    task test_random();
        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
            if (mem[i][31:24] == 8'hFF) mem[i][31] = 1'b0;
        end
        hold_reset();
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0, 1'($urandom), 6'($urandom));
            #1;
            checks++; if (inst_valid !== m_valid) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%0b exp=%0b", n, inst_valid, m_valid); end
            if (m_valid) begin
                checks++; if (inst_pc !== m_pc || inst !== mem[m_pc]) begin errors++; $display("FAIL rnd_inst cyc=%0d got=%0d/%0h exp=%0d/%0h", n, inst_pc, inst, m_pc, mem[m_pc]); end
                if (!inst_ready) begin
                    checks++; if (imem_addr !== m_pc || imem_en !== 1'b1) begin errors++; $display("FAIL rnd_stall_addr cyc=%0d got=%0d exp=%0d", n, imem_addr, m_pc); end
                end
            end
            checks++; if (retired_cnt !== m_cnt || halted !== 1'b0) begin errors++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", n, retired_cnt, m_cnt); end
            tick();
        end
    endtask

    task test_halt();
        for (int i = 0; i < 64; i++) mem[i] = i;
        mem[5] = 32'hFF00_0000;
        drive(1, 0, 0, 0, 0);
        hold_reset();
        for (int n = 0; n < 20 && !m_halt; n++) begin
            checks++; if (inst_valid !== m_valid || (m_valid && inst_pc !== m_pc)) begin errors++; $display("FAIL halt_run got=%0b/%0d exp=%0b/%0d", inst_valid, inst_pc, m_valid, m_pc); end
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            checks++; if (halted !== 1'b1 || inst_valid !== 1'b0 || imem_en !== 1'b0) begin errors++; $display("FAIL halt_state got=%0b/%0b/%0b exp=1/0/0", halted, inst_valid, imem_en); end
            checks++; if (retired_cnt !== 8'd6) begin errors++; $display("FAIL halt_cnt got=%0d exp=6", retired_cnt); end
            tick();
        end
        mem[5] = 32'd5;
        rst = 0;
        model_reset();
        #1;
        checks++; if (halted !== 1'b0 || imem_en !== 1'b0 || retired_cnt !== 8'd0) begin errors++; $display("FAIL halt_rst got=%0b/%0b/%0d exp=0/0/0", halted, imem_en, retired_cnt); end
        @(negedge clk);
        rst = 1;
        tick();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 6'd0 || inst !== 32'd0) begin errors++; $display("FAIL reboot got=%0b/%0d exp=1/0", inst_valid, inst_pc); end
        tick();
        checks++; if (inst_pc !== 6'd1 || retired_cnt !== 8'd1) begin errors++; $display("FAIL reboot_next got=%0d/%0d exp=1/1", inst_pc, retired_cnt); end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_jump();
        test_cond();
        test_wrap();
        test_random();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
